// File: rtl/dru_pkg.sv
// Shared definitions for the DRU bit packer: slip tracking states and the
// encodings carried on in_count.
package dru_pkg;

    // Bitslip tracking: a slip request waits in SLIP_PENDING until a bit
    // arrives to be discarded.
    typedef enum logic {
        SLIP_IDLE    = 1'b0,
        SLIP_PENDING = 1'b1
    } slip_state_t;

    // Values that appear on in_count.
    localparam logic [1:0] CNT_NONE    = 2'd0;
    localparam logic [1:0] CNT_ONE     = 2'd1;
    localparam logic [1:0] CNT_TWO     = 2'd2;
    localparam logic [1:0] CNT_ILLEGAL = 2'd3;

    // True when in_count carries the code that is flagged as an error.
    function automatic logic is_illegal_count(input logic [1:0] cnt);
        return cnt == CNT_ILLEGAL;
    endfunction

endpackage

// File: rtl/dru_sync_fifo.sv
// Small synchronous FIFO with a registered head-of-queue output.
// rd_data always presents the oldest entry while empty is low. It is
// refreshed on the same edge as any push or pop, so a word written into an
// empty FIFO is visible one cycle after the write.
module dru_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    import dru_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count;
    logic [AW:0]      count_after_rd;
    logic [AW:0]      count_next;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Qualify requests and work out the occupancy after this edge.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        do_rd          = rd_en && !empty;
        do_wr          = wr_en && (!full || do_rd);
        rd_ptr_next    = rd_ptr + AW'(do_rd);
        count_after_rd = count - (AW+1)'(do_rd);
        count_next     = count_after_rd + (AW+1)'(do_wr);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count reset, so stale contents are never observed.
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Registered head of queue; bypass the write when it becomes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (count_next != '0) begin
            if (count_after_rd == '0) rd_data <= wr_data;
            else                      rd_data <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/dru_bit_packer.sv
// Packs the 0..2 recovered bits per cycle from the data recovery unit into
// WORD_W-bit words, first-received bit in bit 0, and queues them in an
// output FIFO. A bitslip request discards one upcoming bit. All outputs are
// registered, so nothing on in_bits or in_count reaches an output in the
// same cycle.
module dru_bit_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_bits,
    input  logic [1:0]        in_count,
    input  logic              bitslip,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              err_count
);
    import dru_pkg::*;

    // Wide enough to hold fill + 2, i.e. up to WORD_W + 1.
    localparam int FILL_W = $clog2(WORD_W + 2);

    slip_state_t       slip_state;
    slip_state_t       slip_state_next;
    logic              slip_req;
    logic [1:0]        take_n;
    logic [1:0]        take_bits;

    logic [WORD_W:0]   acc;
    logic [WORD_W:0]   acc_merged;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_total;
    logic              word_done;

    logic              fifo_full;
    logic              fifo_empty;

    assign slip_req  = (slip_state == SLIP_PENDING) || bitslip;
    assign out_valid = !fifo_empty;

    // Slip state register.
    always_ff @(posedge clk) begin
        if (rst) slip_state <= SLIP_IDLE;
        else     slip_state <= slip_state_next;
    end

    // Slip next state: any arriving bit consumes the slip, otherwise it waits.
    always_comb begin
        slip_state_next = SLIP_IDLE;
        case (in_count)
            CNT_ONE, CNT_TWO: slip_state_next = SLIP_IDLE;
            default:          slip_state_next = slip_req ? SLIP_PENDING : SLIP_IDLE;
        endcase
    end

    // Accepted bits this cycle after any slip discards, packed from bit 0.
    // A fresh bitslip while a slip is pending is ignored unless a second bit
    // is available this cycle, in which case it discards that bit too.
    always_comb begin
        take_n    = 2'd0;
        take_bits = 2'b00;
        case (in_count)
            CNT_ONE: begin
                if (!slip_req) begin
                    take_n    = 2'd1;
                    take_bits = {1'b0, in_bits[0]};
                end
            end
            CNT_TWO: begin
                if (slip_state == SLIP_PENDING && bitslip) begin
                    take_n = 2'd0;
                end else if (slip_req) begin
                    take_n    = 2'd1;
                    take_bits = {1'b0, in_bits[1]};
                end else begin
                    take_n    = 2'd2;
                    take_bits = in_bits;
                end
            end
            default: begin
                take_n    = 2'd0;
                take_bits = 2'b00;
            end
        endcase
    end

    // Merge the accepted bits above the current fill and detect completion.
    always_comb begin
        acc_merged = acc | ((WORD_W+1)'(take_bits) << fill);
        fill_total = fill + FILL_W'(take_n);
        word_done  = (fill_total >= FILL_W'(WORD_W));
    end

    // Accumulator and fill; an excess bit becomes bit 0 of the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            fill <= '0;
        end else if (word_done) begin
            if (fill_total == FILL_W'(WORD_W + 1)) begin
                acc  <= {{WORD_W{1'b0}}, acc_merged[WORD_W]};
                fill <= FILL_W'(1);
            end else begin
                acc  <= '0;
                fill <= '0;
            end
        end else begin
            acc  <= acc_merged;
            fill <= fill_total;
        end
    end

    // Sticky overflow when a finished word meets a full FIFO with no pop,
    // and a one-cycle error pulse for the illegal count code.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            err_count <= 1'b0;
        end else begin
            if (word_done && fifo_full && !out_ready) overflow <= 1'b1;
            err_count <= is_illegal_count(in_count);
        end
    end

    dru_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (word_done),
        .wr_data (acc_merged[WORD_W-1:0]),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_dru_bit_packer.sv
// Testbench for dru_bit_packer: directed stimulus, a bit-queue reference
// model compared every cycle, and literal expectations for key words.
module tb_dru_bit_packer;

    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        in_bits;
    logic [1:0]        in_count;
    logic              bitslip;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
    logic              err_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    dru_bit_packer #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bits   (in_bits),
        .in_count  (in_count),
        .bitslip   (bitslip),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bits are kept as a plain stream; words are cut WORD_W bits at a time.
    bit                m_bits[$];
    logic [WORD_W-1:0] m_fifo[$];
    bit                m_ovf;
    bit                m_err;
    bit                m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_bits.delete();
            m_fifo.delete();
            m_ovf  = 1'b0;
            m_err  = 1'b0;
            m_pend = 1'b0;
        end else begin
            bit pop;
            int n;
            int owed;
            logic [WORD_W-1:0] w;
            pop   = (m_fifo.size() > 0) && out_ready;
            m_err = (in_count == 2'd3);
            n     = (in_count == 2'd3) ? 0 : int'(in_count);
            owed  = m_pend ? 1 : 0;
            if (bitslip) begin
                if (!m_pend)     owed = 1;
                else if (n == 2) owed = 2;
            end
            for (int i = 0; i < n; i++) begin
                if (owed > 0) owed--;
                else          m_bits.push_back(in_bits[i]);
            end
            m_pend = (owed > 0);
            if (pop) void'(m_fifo.pop_front());
            if (m_bits.size() >= WORD_W) begin
                for (int i = 0; i < WORD_W; i++) w[i] = m_bits.pop_front();
                if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(w);
                else                            m_ovf = 1'b1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) check("cyc_out_data", 32'(out_data), 32'(m_fifo[0]));
            check("cyc_overflow", 32'(overflow), 32'(m_ovf));
            check("cyc_err_count", 32'(err_count), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] b, input logic [1:0] c, input logic s, input logic r);
        in_bits   = b;
        in_count  = c;
        bitslip   = s;
        out_ready = r;
        @(posedge clk);
        #1;
        bitslip  = 1'b0;
        in_count = 2'd0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic word_pairs(input logic [1:0] p0, input logic [1:0] p1,
                              input logic [1:0] p2, input logic [1:0] p3, input logic r_last);
        drive(p0, 2'd2, 1'b0, 1'b0);
        drive(p1, 2'd2, 1'b0, 1'b0);
        drive(p2, 2'd2, 1'b0, 1'b0);
        drive(p3, 2'd2, 1'b0, r_last);
    endtask

    initial begin
        logic [7:0] seq1;
        logic [7:0] exp4 [4];
        logic [7:0] fresh;
        seq1    = 8'b0100_1101;          // bits 1,0,1,1,0,0,1,0 with first in bit 0
        exp4[0] = 8'h55; exp4[1] = 8'hAA; exp4[2] = 8'hFF; exp4[3] = 8'h00;
        fresh   = 8'hF0;                 // bits 0,0,0,0,1,1,1,1

        // Reset with junk on the inputs.
        rst = 1'b1; in_bits = 2'b11; in_count = 2'd2; bitslip = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0; in_count = 2'd0; bitslip = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // Single bits 1,0,1,1,0,0,1,0.
        for (int i = 0; i < 8; i++) begin
            drive({1'b0, seq1[i]}, 2'd1, 1'b0, 1'b0);
            if (i == 6) check("seq1_not_yet_valid", 32'(out_valid), 32'd0);
        end
        check("seq1_valid", 32'(out_valid), 32'd1);
        check("seq1_word", 32'(out_data), 32'h4D);
        drive(2'b00, 2'd0, 1'b0, 1'b0);
        check("seq1_stable", 32'(out_data), 32'h4D);
        drain(2);

        // Four pairs of 2'b01 -> 0x55.
        word_pairs(2'b01, 2'b01, 2'b01, 2'b01, 1'b0);
        check("pairs_word", 32'(out_data), 32'h55);
        drain(2);

        // 9 bits: counts 2,2,2,1,2 -> 0xFF, residual 0 leads the next word.
        drive(2'b11, 2'd2, 1'b0, 1'b0);
        drive(2'b11, 2'd2, 1'b0, 1'b0);
        drive(2'b11, 2'd2, 1'b0, 1'b0);
        drive(2'b01, 2'd1, 1'b0, 1'b0);
        drive(2'b01, 2'd2, 1'b0, 1'b0);
        check("excess_word", 32'(out_data), 32'hFF);
        for (int i = 0; i < 7; i++) drive(2'b01, 2'd1, 1'b0, 1'b1);
        check("residual_word", 32'(out_data), 32'hFE);
        drain(2);

        // Overflow: five words with no consumer.
        word_pairs(2'b01, 2'b01, 2'b01, 2'b01, 1'b0);
        word_pairs(2'b10, 2'b10, 2'b10, 2'b10, 1'b0);
        word_pairs(2'b11, 2'b11, 2'b11, 2'b11, 1'b0);
        word_pairs(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        check("ovf_clear_at_full", 32'(overflow), 32'd0);
        word_pairs(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_drain_%0d", k), 32'(out_data), 32'(exp4[k]));
            drive(2'b00, 2'd0, 1'b0, 1'b1);
        end
        check("ovf_fifth_absent", 32'(out_valid), 32'd0);

        // Bitslip then 0 followed by eight 1s -> 0xFF.
        drive(2'b00, 2'd0, 1'b1, 1'b0);
        drive(2'b00, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(2'b01, 2'd1, 1'b0, 1'b0);
        check("slip_word", 32'(out_data), 32'hFF);
        drain(2);

        // Slip with a pair, then pending slip plus new slip on a pair.
        drive(2'b10, 2'd2, 1'b1, 1'b0);  // keeps the 1
        drive(2'b00, 2'd0, 1'b1, 1'b0);  // arm
        drive(2'b11, 2'd2, 1'b1, 1'b0);  // both bits discarded
        for (int i = 0; i < 7; i++) drive(2'b00, 2'd1, 1'b0, 1'b0);
        check("slip_pair_word", 32'(out_data), 32'h01);
        drain(2);

        // Second slip while pending is ignored.
        drive(2'b00, 2'd0, 1'b1, 1'b0);
        drive(2'b00, 2'd0, 1'b1, 1'b0);
        drive(2'b00, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(2'b01, 2'd1, 1'b0, 1'b0);
        check("slip_twice_word", 32'(out_data), 32'hFF);
        drain(2);

        // Illegal count mid-word: error pulse, fill unchanged.
        drive(2'b01, 2'd1, 1'b0, 1'b0);
        drive(2'b01, 2'd1, 1'b0, 1'b0);
        drive(2'b00, 2'd1, 1'b0, 1'b0);
        drive(2'b11, 2'd3, 1'b0, 1'b0);
        check("err_pulse", 32'(err_count), 32'd1);
        drive(2'b01, 2'd1, 1'b0, 1'b0);
        check("err_pulse_end", 32'(err_count), 32'd0);
        drive(2'b00, 2'd1, 1'b0, 1'b0);
        drive(2'b01, 2'd1, 1'b0, 1'b0);
        drive(2'b00, 2'd1, 1'b0, 1'b0);
        drive(2'b01, 2'd1, 1'b0, 1'b0);
        check("err_word", 32'(out_data), 32'hAB);

        // Reset mid-word with queued data and sticky overflow.
        for (int i = 0; i < 5; i++) drive(2'b01, 2'd1, 1'b0, 1'b0);
        rst = 1'b1;
        drive(2'b11, 2'd2, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) drive({1'b0, fresh[i]}, 2'd1, 1'b0, 1'b0);
        check("rst2_fresh_word", 32'(out_data), 32'hF0);
        drain(2);

        // Full FIFO with push and pop on the same edge: no overflow.
        word_pairs(2'b01, 2'b01, 2'b01, 2'b01, 1'b0);
        word_pairs(2'b10, 2'b10, 2'b10, 2'b10, 1'b0);
        word_pairs(2'b00, 2'b11, 2'b00, 2'b11, 1'b0);
        word_pairs(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
        word_pairs(2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        check("full_pushpop_head", 32'(out_data), 32'hAA);
        drain(6);
        check("final_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dru_bit_packer.md
DRU_BIT_PACKER -- requirements
Module: dru_bit_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, output word width in bits (4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_bits  input  2  recovered bits from data_recovery_unit; in_bits[0] is earlier in time.
REQ-006 SHALL have port in_count  input  2  number of valid bits in in_bits this cycle (0, 1, 2; 3 illegal).
REQ-007 SHALL have port bitslip  input  1  one-cycle pulse; discard the next accepted bit.
REQ-008 SHALL have port out_data  output  WORD_W  packed word at FIFO head; first-received bit in out_data[0].
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word when out_valid&out_ready.
REQ-011 SHALL have port overflow  output  1  sticky; a completed word was dropped.
REQ-012 SHALL have port err_count  output  1  one-cycle pulse, registered, for in_count==3.

Function
REQ-013 SHALL accept in_count bits every cycle unconditionally; no input backpressure.
REQ-014 SHALL hold partial bits in an accumulator of WORD_W+1 bits and a fill counter 0..WORD_W.
REQ-015 SHALL complete a word when fill+accepted bits >= WORD_W; excess bit (fill==WORD_W-1, count 2) SHALL become bit 0 of the next word, fill=1.
REQ-016 SHALL push a completed word into the FIFO on the same edge it completes; out_valid SHALL rise on the next cycle (latency 1 from final bit).
REQ-017 SHALL pop the FIFO on out_valid&out_ready; out_data SHALL be stable while out_valid&!out_ready.
REQ-018 SHALL allow simultaneous push and pop when full; no overflow in that case.
REQ-019 SHALL drop the completed word, keep FIFO contents, and set overflow when FIFO is full with no pop on the completion edge.
REQ-020 SHALL treat in_count==3 as 0 bits accepted and pulse err_count the following cycle.
REQ-021 SHALL track bitslip with a pending flag: IDLE -> SLIP_PENDING on bitslip; SLIP_PENDING -> IDLE when the next bit is accepted, which is discarded.
REQ-022 SHALL, with bitslip and in_count==2 on the same cycle, discard in_bits[0] and accept in_bits[1].
REQ-023 SHALL, with bitslip and in_count==0, keep the slip pending until a bit arrives; a second bitslip while pending SHALL be ignored.
REQ-024 SHALL, when SLIP_PENDING and in_count==2 arrive together with a new bitslip, consume the pending slip on in_bits[0] and immediately re-arm for in_bits[1] discard.

Reset
REQ-025 SHALL, on rst, clear accumulator, fill=0, FIFO pointers, out_valid=0, out_data=0, overflow=0, err_count=0, slip state IDLE.
REQ-026 SHALL, on rst mid-word or with FIFO non-empty, discard all partial and queued data; inputs during rst ignored.
REQ-027 SHALL resume accepting bits the first cycle rst is low.

Structure
REQ-028 SHALL place the slip-state encoding and the in_count legal-value constants in shared package dru_pkg.
REQ-029 SHALL implement the FIFO as sub-module dru_sync_fifo (WIDTH, DEPTH parameters, full/empty flags, registered read data).
REQ-030 SHALL contain no combinational path from in_bits/in_count to any output.

Verification
REQ-031 SHALL verify: count=1 bits 1,0,1,1,0,0,1,0 over 8 cycles -> out_data=8'b01001101, out_valid high the cycle after the 8th bit.
REQ-032 SHALL verify: four cycles count=2, in_bits=2'b01 -> single word 8'h55.
REQ-033 SHALL verify: counts 2,2,2,1,2 (9 bits, all ones then final 2'b01 pair) -> word 8'hFF, residual bit 0 leads next word, fill=1.
REQ-034 SHALL verify: out_ready=0, five words pushed, FIFO_DEPTH=4 -> overflow=1, then out_ready=1 yields first four words in order, fifth absent.
REQ-035 SHALL verify: bitslip pulse then count=1 bits 0,1,1,1,1,1,1,1,1 -> first 0 dropped, word 8'hFF.
REQ-036 SHALL verify: in_count=3 mid-word -> err_count pulse, fill unchanged; rst asserted with fill=5 -> next word built from fresh bits only.
